// File: rtl/ghash_digit_mult.sv
// Digit-serial GF(2^128) multiplier for GHASH: consumes DIGIT_WIDTH bits of the
// operand per cycle against H, with an optional X = (X xor A)*H accumulator.
module ghash_digit_mult #(
  parameter int DATA_WIDTH  = 128,
  parameter int DIGIT_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  input  logic [DATA_WIDTH-1:0] a_i,
  input  logic [DATA_WIDTH-1:0] h_i,
  input  logic                  accum_i,
  input  logic                  clear_i,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [DATA_WIDTH-1:0] x_o
);

  localparam int N     = DATA_WIDTH / DIGIT_WIDTH;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [DATA_WIDTH-1:0] R = {8'hE1, {(DATA_WIDTH-8){1'b0}}};

  if (DATA_WIDTH != 128) begin : g_bad_width
    $error("ghash_digit_mult: DATA_WIDTH must be 128");
  end
  if (!(DIGIT_WIDTH == 1 || DIGIT_WIDTH == 2 || DIGIT_WIDTH == 4 || DIGIT_WIDTH == 8 ||
        DIGIT_WIDTH == 16 || DIGIT_WIDTH == 32 || DIGIT_WIDTH == 64 || DIGIT_WIDTH == 128))
  begin : g_bad_digit
    $error("ghash_digit_mult: DIGIT_WIDTH must be a power of two from 1 to 128");
  end

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t                state, state_next;
  logic [DATA_WIDTH-1:0] acc, op, v, z, x;
  logic                  accum_flag;
  logic [CNT_W-1:0]      cnt;
  logic [DATA_WIDTH-1:0] z_step, v_step, op_step;
  logic                  last;

  // One digit of the right-shift GCM algorithm, operand consumed MSB (x^0) first.
  always_comb begin
    z_step  = z;
    v_step  = v;
    op_step = op;
    for (int i = 0; i < DIGIT_WIDTH; i++) begin
      if (op_step[DATA_WIDTH-1]) z_step = z_step ^ v_step;
      v_step  = v_step[0] ? ((v_step >> 1) ^ R) : (v_step >> 1);
      op_step = op_step << 1;
    end
  end

  assign last = (cnt == CNT_W'(N - 1));

  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (in_valid_i)  state_next = BUSY;
      BUSY:    if (last)        state_next = DONE;
      DONE:    if (out_ready_i) state_next = IDLE;
      default:                  state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      acc        <= '0;
      op         <= '0;
      v          <= '0;
      z          <= '0;
      x          <= '0;
      accum_flag <= 1'b0;
      cnt        <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (clear_i) acc <= '0;
          // A same-cycle clear wins, so the accumulator contributes zero.
          if (in_valid_i) begin
            v          <= h_i;
            op         <= a_i ^ ((accum_i && !clear_i) ? acc : '0);
            accum_flag <= accum_i;
            z          <= '0;
            cnt        <= '0;
          end
        end
        BUSY: begin
          z   <= z_step;
          v   <= v_step;
          op  <= op_step;
          cnt <= cnt + 1'b1;
          if (last) begin
            x <= z_step;
            if (accum_flag) acc <= z_step;
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready_o  = (state == IDLE) && rst;
  assign out_valid_o = (state == DONE);
  assign x_o         = x;

endmodule
